// File: rtl/s2p_frame_sequencer.sv
// Framing controller and one-entry output buffer for a WIDTH-bit serial-to-parallel
// deserializer: bit counter, IDLE/SHIFT sequencing, valid/ready holding register, sticky overrun.
module s2p_frame_sequencer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             frame_start,
    input  logic             frame_abort,
    input  logic             data_ready,
    input  logic             overrun_clr,
    output logic             shift_enable,
    output logic             busy,
    output logic [5:0]       bit_count,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             overrun
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    localparam logic [5:0] WIDTH_CNT = 6'(WIDTH);

    state_t           state_q, state_d;
    logic [5:0]       count_q, count_d, accept_count;
    logic [WIDTH-1:0] sreg_q, sreg_d, shift_base, shifted;
    logic             word_done, take_word, drop_word;

    // A completed word keeps the FSM in SHIFT with count==WIDTH for one cycle;
    // only a frame_start bit may be accepted then, which gives back-to-back framing.
    always_comb begin
        shift_enable = 1'b0;
        if (bit_valid && !frame_abort) begin
            if (state_q == IDLE) begin
                shift_enable = frame_start;
            end else begin
                shift_enable = frame_start || (count_q != WIDTH_CNT);
            end
        end
    end

    assign accept_count = frame_start ? 6'd1 : (count_q + 6'd1);
    assign shift_base   = frame_start ? '0 : sreg_q;

    if (MSB_FIRST) begin : g_msb_first
        assign shifted = {shift_base[WIDTH-2:0], bit_in};
    end else begin : g_lsb_first
        assign shifted = {bit_in, shift_base[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sreg_d  = sreg_q;
        if (frame_abort) begin
            state_d = IDLE;
            count_d = 6'd0;
        end else if (shift_enable) begin
            state_d = SHIFT;
            count_d = accept_count;
            sreg_d  = shifted;
        end else if ((state_q == SHIFT) && (count_q == WIDTH_CNT)) begin
            state_d = IDLE;
            count_d = 6'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= 6'd0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sreg_q  <= sreg_d;
        end
    end

    // Handshake: data_valid=1 means data_out holds an unconsumed word; a transfer happens
    // on any edge where data_valid & data_ready, and a completing word may replace it on that edge.
    assign word_done = shift_enable && (accept_count == WIDTH_CNT);
    assign take_word = word_done && (!data_valid || data_ready);
    assign drop_word = word_done && data_valid && !data_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (take_word) begin
                data_out   <= shifted;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            overrun <= drop_word || (overrun && !overrun_clr);
        end
    end

    assign busy      = (state_q == SHIFT);
    assign bit_count = count_q;

endmodule

// File: tb/tb_s2p_frame_sequencer.sv
// Bench for s2p_frame_sequencer: an MSB-first and an LSB-first instance share stimulus and
// are compared every cycle against a queue-of-bits framing model.
module tb_s2p_frame_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_valid = 1'b0, bit_in = 1'b0, frame_start = 1'b0, frame_abort = 1'b0;
  logic data_ready = 1'b0, overrun_clr = 1'b0;

  logic       se_m, busy_m, dv_m, ovr_m;
  logic [5:0] cnt_m;
  logic [7:0] dout_m;
  logic       se_l, busy_l, dv_l, ovr_l;
  logic [5:0] cnt_l;
  logic [7:0] dout_l;

  int n_checks = 0;
  int n_fail = 0;
  int se_cnt = 0;

  // reference model state
  logic       m_bits[$];
  bit         m_active = 0;
  bit         m_dv = 0;
  bit         m_ovr = 0;
  logic [7:0] m_out_m = '0;
  logic [7:0] m_out_l = '0;

  always #5 clk = ~clk;

  s2p_frame_sequencer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
    .frame_start(frame_start), .frame_abort(frame_abort), .data_ready(data_ready),
    .overrun_clr(overrun_clr), .shift_enable(se_m), .busy(busy_m), .bit_count(cnt_m),
    .data_out(dout_m), .data_valid(dv_m), .overrun(ovr_m)
  );

  s2p_frame_sequencer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
    .frame_start(frame_start), .frame_abort(frame_abort), .data_ready(data_ready),
    .overrun_clr(overrun_clr), .shift_enable(se_l), .busy(busy_l), .bit_count(cnt_l),
    .data_out(dout_l), .data_valid(dv_l), .overrun(ovr_l)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [5:0] e_cnt;
    e_cnt = 6'(m_bits.size());
    chk("busy_m", busy_m, m_active);
    chk("busy_l", busy_l, m_active);
    chk("bit_count_m", cnt_m, e_cnt);
    chk("bit_count_l", cnt_l, e_cnt);
    chk("data_valid_m", dv_m, m_dv);
    chk("data_valid_l", dv_l, m_dv);
    chk("data_out_m", dout_m, m_out_m);
    chk("data_out_l", dout_l, m_out_l);
    chk("overrun_m", ovr_m, m_ovr);
    chk("overrun_l", ovr_l, m_ovr);
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic step(input bit bv, input bit b, input bit fs, input bit fa,
                      input bit dr, input bit oc);
    bit e_se, done, drop;
    bit_valid = bv; bit_in = b; frame_start = fs; frame_abort = fa;
    data_ready = dr; overrun_clr = oc;
    e_se = bv && !fa && (fs || (m_active && m_bits.size() < 8));
    #3;
    chk("shift_enable_m", se_m, e_se);
    chk("shift_enable_l", se_l, e_se);
    if (se_l) se_cnt++;
    @(posedge clk);
    done = 0;
    drop = 0;
    if (fa) begin
      m_bits.delete();
      m_active = 0;
    end else if (e_se) begin
      if (fs) m_bits.delete();
      m_bits.push_back(b);
      m_active = 1;
      done = (m_bits.size() == 8);
    end else if (m_active && m_bits.size() == 8) begin
      m_bits.delete();
      m_active = 0;
    end
    if (done) begin
      if (!m_dv || dr) begin
        m_dv = 1;
        for (int i = 0; i < 8; i++) begin
          m_out_m[7-i] = m_bits[i];
          m_out_l[i]   = m_bits[i];
        end
      end else begin
        drop = 1;
      end
    end else if (m_dv && dr) begin
      m_dv = 0;
    end
    m_ovr = drop || (m_ovr && !oc);
    #1;
    check_outputs();
  endtask

  task automatic idle(input bit dr);
    step(0, 0, 0, 0, dr, 0);
  endtask

  // Sends the first n bits of seq, seq[7] first, frame_start on the first bit.
  task automatic send_frame(input logic [7:0] seq, input int n, input bit gaps,
                            input bit dr, input bit dr_last, input bit oc_last);
    logic [7:0] s;
    s = seq;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) step(0, 0, 0, 0, dr, 0);
      if (i == n - 1) step(1, s[7-i], i == 0, 0, dr_last, oc_last);
      else            step(1, s[7-i], i == 0, 0, dr, 0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy_m, 0);
    chk("reset_count", cnt_m, 0);
    chk("reset_dout", dout_l, 0);
    chk("reset_dv", dv_l, 0);
    chk("reset_ovr", ovr_m, 0);
    rst = 1'b0;
    idle(0);

    // MSB-first byte, bits 1,0,1,0,0,1,0,1
    send_frame(8'hA5, 8, 0, 0, 0, 0);
    chk("a5_dout_m", dout_m, 8'hA5);
    chk("a5_dv", dv_m, 1);
    chk("a5_count_8", cnt_m, 8);
    idle(1);
    chk("a5_count_0", cnt_m, 0);

    // LSB-first with gaps
    se_cnt = 0;
    send_frame(8'hA5, 8, 1, 0, 0, 0);
    chk("gap_dout_l", dout_l, 8'hA5);
    chk("gap_se_pulses", se_cnt, 8);
    idle(1);

    // backpressure and overrun
    send_frame(8'h3C, 8, 0, 0, 0, 0);
    send_frame(8'hC3, 8, 0, 0, 0, 0);
    chk("bp_dout", dout_m, 8'h3C);
    chk("bp_ovr", ovr_m, 1);
    send_frame(8'hC3, 8, 0, 0, 0, 1);
    chk("ovr_set_wins", ovr_l, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("ovr_clr", ovr_l, 0);
    idle(1);

    // abort with frame_start and bit_valid present, then full frame
    send_frame(8'hFF, 3, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    chk("abort_count", cnt_m, 0);
    send_frame(8'h81, 8, 0, 0, 0, 0);
    chk("abort_dout", dout_m, 8'h81);
    idle(1);

    // restart mid-word
    send_frame(8'hFF, 5, 0, 0, 0, 0);
    send_frame(8'h7E, 8, 0, 0, 0, 0);
    chk("restart_dout", dout_l, 8'h7E);

    // consume and complete on the same edge
    send_frame(8'h66, 8, 0, 0, 1, 0);
    chk("sim_dout", dout_m, 8'h66);
    chk("sim_dv", dv_m, 1);
    chk("sim_ovr", ovr_m, 0);
    idle(1);

    // asynchronous reset mid-word
    send_frame(8'h3C, 4, 0, 0, 0, 0);
    bit_valid = 0; bit_in = 0; frame_start = 0; frame_abort = 0;
    data_ready = 0; overrun_clr = 0;
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy_m, 0);
    chk("arst_count", cnt_l, 0);
    chk("arst_dout", dout_m, 0);
    chk("arst_dv", dv_l, 0);
    m_bits.delete(); m_active = 0; m_dv = 0; m_ovr = 0; m_out_m = '0; m_out_l = '0;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame(8'hA5, 8, 0, 0, 0, 0);
    chk("arst_next_dout", dout_m, 8'hA5);
    idle(1);

    // randomized traffic, including non-palindromic words
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1),
           $urandom_range(0, 24) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 1), $urandom_range(0, 19) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/s2p_frame_sequencer.md
# s2p_frame_sequencer

Framing controller and output buffer for an 8-bit serial-to-parallel deserializer. Accepts a qualified serial bit stream, sequences the internal shift register with a bit counter, and delivers each completed word through a one-entry valid/ready holding register. Words that arrive while the register is still full are dropped and reported on a sticky overrun flag. Sits between a serial line front end and the byte-wide consumer logic.

## Interface
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in data_out[WIDTH-1]; 0 = first received bit lands in data_out[0].

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, asynchronous and active-high.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_in  in  1  serial data bit.
- frame_start  in  1  marks the first bit of a word; sampled only when bit_valid=1.
- frame_abort  in  1  discards the partial word; level-sampled.
- data_ready  in  1  consumer accepts data_out this cycle.
- overrun_clr  in  1  clears overrun.
- shift_enable  out  1  combinational; 1 when a bit is accepted this cycle.
- busy  out  1  state is SHIFT.
- bit_count  out  6  number of bits accepted in the current word.
- data_out  out  WIDTH  held word.
- data_valid  out  1  data_out holds an unconsumed word.
- overrun  out  1  sticky; a completed word was dropped.

## Operation
- States: IDLE, SHIFT.
- IDLE:
  - Accept a bit only when bit_valid & frame_start & !frame_abort.
  - On accept: shift the bit into the shift register, set bit_count=1, go to SHIFT.
  - Any other bit_valid is ignored; shift_enable stays 0.
- SHIFT:
  - On bit_valid & !frame_abort: shift, bit_count+1.
  - On bit_valid & frame_start: restart. Discard the partial word, the current bit becomes bit 1, bit_count=1, stay in SHIFT.
- Completion: the WIDTH-th accepted bit completes the word.
  - Next edge: state returns to IDLE and bit_count=0.
  - The next word requires frame_start.
- Abort: frame_abort=1 in any state sends the block to IDLE with bit_count=0 and shift_enable=0.
  - Abort has priority over frame_start and bit_valid.
  - The holding register is unaffected.
- Shift direction:
  - MSB_FIRST=1: shift left, new bit enters at LSB.
  - MSB_FIRST=0: shift right, new bit enters at MSB.
- Holding register, evaluated at the completion edge:
  - If data_valid=0, or data_valid=1 with data_ready=1: load the word, data_valid=1.
  - If data_valid=1 and data_ready=0: drop the word, data_out unchanged, overrun set to 1.
  - Outside a completion edge, data_ready=1 with data_valid=1 clears data_valid.
  - data_out holds its last value after being consumed.
- overrun:
  - Set by a drop; cleared by overrun_clr.
  - A drop and overrun_clr in the same cycle leave overrun=1 (set wins).
- Reset: state IDLE; shift register, bit_count, data_out, data_valid and overrun all 0.
  - Reset asserted mid-word discards the partial word.

## Timing
- Latency: data_valid rises on the edge that samples the WIDTH-th bit. The word is visible in the cycle after the last bit.
- Throughput: one bit per cycle. Back-to-back words are allowed (frame_start on the cycle after completion), giving a minimum of WIDTH cycles per word.
- Gaps in bit_valid are allowed in SHIFT. There is no timeout.
- shift_enable and the transfer of the consumed word via data_ready are combinational from inputs and current state. No other output has a combinational input-to-output path.
- bit_count, busy, data_out, data_valid and overrun are registered.

## Test plan
- MSB-first byte: MSB_FIRST=1. Drive bits 1,0,1,0,0,1,0,1 on consecutive cycles, frame_start on the first bit. Expect data_out=8'hA5 and data_valid=1 one cycle after the 8th bit, with bit_count stepping 1..8 and then 0.
- LSB-first with gaps: MSB_FIRST=0. Send the same bit sequence with bit_valid low every other cycle. Expect data_out=8'hA5, shift_enable pulsed exactly 8 times, busy high throughout the frame.
- Backpressure and overrun:
  - Send 8'h3C with data_ready=0, then 8'hC3 with data_ready=0. Expect data_out=8'h3C, overrun=1.
  - Assert overrun_clr on the same cycle as a third drop. Expect overrun to stay 1.
  - Assert overrun_clr alone. Expect overrun=0.
- Abort and restart:
  - Send 3 bits, assert frame_abort, then a full frame carrying 8'h81. Expect 8'h81 only.
  - Send 5 bits, then frame_start with 8 new bits carrying 8'h7E. Expect 8'h7E.
- Simultaneous consume and complete: hold data_valid=1 with data_ready=1 on the completion edge. Expect the new word loaded, data_valid continuously 1, overrun=0.
- Reset mid-word: after 4 bits, pulse rst asynchronously between edges. Expect all outputs to go to 0 immediately, and the next full frame to decode correctly.
